sccb_target: RTL and testbench

//  SCCB (I2C-compatible) target (responder) for OmniVision-style 3-phase writes and 2-phase reads.

---
 rtl/sccb_target.sv | 221 ++++++++++++++++++++++
 tb/tb_sccb_target.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sccb_target : SCCB target bridging SIOC/SIOD onto a byte register port.  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module sccb_target #(
  parameter logic [7:0]  DEV_ID      = 8'h42,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sioc_i,
  inout  wire        siod_io,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  output logic       reg_re_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DEV_ADDR = 3'd1;
  localparam logic [2:0] ST_REG_ADDR = 3'd2;
  localparam logic [2:0] ST_WR_DATA  = 3'd3;
  localparam logic [2:0] ST_RD_DATA  = 3'd4;
  localparam logic [2:0] ST_IGNORE   = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [SYNC_STAGES-1:0] sioc_sync_q, sioc_sync_d;
  logic [SYNC_STAGES-1:0] siod_sync_q, siod_sync_d;
  logic                   sioc_prev_q, sioc_prev_d;
  logic                   siod_prev_q, siod_prev_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             rx_q, rx_d;
  logic [7:0]             tx_q, tx_d;
  logic                   ack_q, ack_d;
  logic                   rw_q, rw_d;
  logic                   first_wr_q, first_wr_d;
  logic                   re_dly_q, re_dly_d;
  logic                   drive_low_q, drive_low_d;
  logic                   busy_q, busy_d;
  logic [7:0]             reg_addr_q, reg_addr_d;
  logic [7:0]             reg_wdata_q, reg_wdata_d;
  logic                   reg_we_q, reg_we_d;
  logic                   reg_re_q, reg_re_d;

  logic       sioc_s, siod_s;
  logic       sioc_rise, sioc_fall;
  logic       start_det, stop_det;
  logic       active;
  logic [7:0] rx_byte;
  logic       id_match;

  assign sioc_s    = sioc_sync_q[SYNC_STAGES-1];
  assign siod_s    = siod_sync_q[SYNC_STAGES-1];
  assign sioc_rise = sioc_s & ~sioc_prev_q;
  assign sioc_fall = ~sioc_s & sioc_prev_q;
  assign start_det = sioc_s & sioc_prev_q & siod_prev_q & ~siod_s;
  assign stop_det  = sioc_s & sioc_prev_q & ~siod_prev_q & siod_s;
  assign rx_byte   = {rx_q[6:0], siod_s};
  assign id_match  = (rx_byte[7:1] == DEV_ID[7:1]);
  assign active    = (state_q == ST_DEV_ADDR) || (state_q == ST_REG_ADDR) ||
                     (state_q == ST_WR_DATA)  || (state_q == ST_RD_DATA);

  // State register and all datapath flops
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      sioc_sync_q <= '1;
      siod_sync_q <= '1;
      sioc_prev_q <= 1'b1;
      siod_prev_q <= 1'b1;
      bit_cnt_q   <= 4'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      ack_q       <= 1'b0;
      rw_q        <= 1'b0;
      first_wr_q  <= 1'b1;
      re_dly_q    <= 1'b0;
      drive_low_q <= 1'b0;
      busy_q      <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sioc_sync_q <= sioc_sync_d;
      siod_sync_q <= siod_sync_d;
      sioc_prev_q <= sioc_prev_d;
      siod_prev_q <= siod_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      ack_q       <= ack_d;
      rw_q        <= rw_d;
      first_wr_q  <= first_wr_d;
      re_dly_q    <= re_dly_d;
      drive_low_q <= drive_low_d;
      busy_q      <= busy_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
    end
  end

  // Next-state logic; bus conditions override whatever byte is in flight
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = ST_IDLE;
    end else if (start_det) begin
      state_d = ST_DEV_ADDR;
    end else if (sioc_rise) begin
      case (state_q)
        ST_DEV_ADDR: begin
          if (bit_cnt_q == 4'd7 && !id_match) state_d = ST_IGNORE;
          else if (bit_cnt_q == 4'd8)         state_d = rw_q ? ST_RD_DATA : ST_REG_ADDR;
        end
        ST_REG_ADDR: if (bit_cnt_q == 4'd8) state_d = ST_WR_DATA;
        ST_RD_DATA:  if (bit_cnt_q == 4'd8 && siod_s) state_d = ST_IGNORE;
        default:     state_d = state_q;
      endcase
    end
  end

  // Output / datapath logic
  always_comb begin
    sioc_sync_d = {sioc_sync_q[SYNC_STAGES-2:0], sioc_i};
    siod_sync_d = {siod_sync_q[SYNC_STAGES-2:0], siod_io};
    sioc_prev_d = sioc_s;
    siod_prev_d = siod_s;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    ack_d       = ack_q;
    rw_d        = rw_q;
    first_wr_d  = first_wr_q;
    re_dly_d    = reg_re_q;
    drive_low_d = drive_low_q;
    busy_d      = busy_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;

    if (start_det || stop_det) begin
      bit_cnt_d  = 4'd0;
      ack_d      = 1'b0;
      first_wr_d = 1'b1;
      busy_d     = 1'b0;
    end else begin
      if (sioc_rise && active) begin
        if (bit_cnt_q == 4'd8) begin
          bit_cnt_d = 4'd0;
          ack_d     = 1'b0;
          if (state_q == ST_RD_DATA && !siod_s) reg_addr_d = reg_addr_q + 8'd1;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          rx_d      = rx_byte;
          if (bit_cnt_q == 4'd7) begin
            case (state_q)
              ST_DEV_ADDR: begin
                if (id_match) begin
                  ack_d  = 1'b1;
                  busy_d = 1'b1;
                  rw_d   = siod_s;
                end
              end
              ST_REG_ADDR: begin
                ack_d      = 1'b1;
                reg_addr_d = rx_byte;
                first_wr_d = 1'b1;
              end
              ST_WR_DATA: begin
                ack_d       = 1'b1;
                reg_wdata_d = rx_byte;
                reg_we_d    = 1'b1;
                reg_addr_d  = first_wr_q ? reg_addr_q : reg_addr_q + 8'd1;
                first_wr_d  = 1'b0;
              end
              default: ack_d = 1'b0;
            endcase
          end
        end
      end

      // SIOD only changes one clock after a detected SIOC fall
      if (sioc_fall) begin
        if (state_q == ST_RD_DATA) begin
          drive_low_d = 1'b0;
          if (bit_cnt_q == 4'd0) begin
            reg_re_d = 1'b1;
          end else if (bit_cnt_q < 4'd8) begin
            drive_low_d = ~tx_q[6];
            tx_d        = {tx_q[6:0], 1'b0};
          end
        end else begin
          drive_low_d = ack_q;
        end
      end

      // Read data arrives the cycle after the strobe; present its MSB at once
      if (re_dly_q && state_q == ST_RD_DATA) begin
        tx_d        = reg_rdata_i;
        drive_low_d = ~reg_rdata_i[7];
      end
    end
  end

  assign siod_io     = drive_low_q ? 1'b0 : 1'bz;
  assign reg_addr_o  = reg_addr_q;
  assign reg_wdata_o = reg_wdata_q;
  assign reg_we_o    = reg_we_q;
  assign reg_re_o    = reg_re_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sccb_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sccb_target : directed bench driving an SCCB initiator at the target.  |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_sccb_target;

  localparam int Q = 8;  // clk_i cycles per quarter SIOC period

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       sioc  = 1'b1;
  logic       host_low = 1'b0;
  logic [7:0] reg_rdata_i = 8'h00;
  wire        siod;
  logic [7:0] reg_addr_o, reg_wdata_o;
  logic       reg_we_o, reg_re_o, busy_o;

  pullup (siod);
  assign siod = host_low ? 1'b0 : 1'bz;

  sccb_target #(.DEV_ID(8'h42), .SYNC_STAGES(2)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .sioc_i      (sioc),
    .siod_io     (siod),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_we_o    (reg_we_o),
    .reg_re_o    (reg_re_o),
    .reg_rdata_i (reg_rdata_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;

  // Event logs filled only by this monitor
  int         we_cnt = 0, re_cnt = 0, drv_cnt = 0, busy_cnt = 0;
  logic [7:0] we_addr_log [0:31];
  logic [7:0] we_data_log [0:31];
  logic [7:0] re_addr_log [0:31];

  always @(negedge clk_i) begin
    if (reg_we_o === 1'b1) begin
      we_addr_log[we_cnt % 32] = reg_addr_o;
      we_data_log[we_cnt % 32] = reg_wdata_o;
      we_cnt = we_cnt + 1;
    end
    if (reg_re_o === 1'b1) begin
      re_addr_log[re_cnt % 32] = reg_addr_o;
      re_cnt = re_cnt + 1;
    end
    if (siod === 1'b0 && !host_low) drv_cnt = drv_cnt + 1;
    if (busy_o === 1'b1) busy_cnt = busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic start_cond();
    host_low = 1'b0; sioc = 1'b1; wait_clk(Q);
    host_low = 1'b1;              wait_clk(Q);
    sioc = 1'b0;                  wait_clk(Q);
  endtask

  task automatic stop_cond();
    host_low = 1'b1; wait_clk(Q);
    sioc = 1'b1;     wait_clk(Q);
    host_low = 1'b0; wait_clk(Q);
  endtask

  task automatic clock_pulse(output logic sampled);
    wait_clk(Q);
    sioc = 1'b1; wait_clk(Q);
    sampled = (siod !== 1'b0);
    wait_clk(Q);
    sioc = 1'b0; wait_clk(Q);
  endtask

  // Returns 1 when the target pulled SIOD low on the 9th clock
  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      host_low = ~b[i];
      clock_pulse(s);
    end
    host_low = 1'b0;
    clock_pulse(s);
    acked = ~s;
  endtask

  task automatic write_bits(input logic [7:0] b, input int nbits);
    logic s;
    for (int i = 7; i > 7 - nbits; i--) begin
      host_low = ~b[i];
      clock_pulse(s);
    end
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic s;
    host_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      clock_pulse(s);
      b[i] = s;
    end
    host_low = ~nack;
    clock_pulse(s);
    host_low = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    logic       a0, a1, a2, a3;
    logic [7:0] rb;
    int         we0, re0, drv0, busy0;

    // Reset state
    wait_clk(4);
    check("rst_addr",  {24'd0, reg_addr_o},  32'h00);
    check("rst_wdata", {24'd0, reg_wdata_o}, 32'h00);
    check("rst_we",    {31'd0, reg_we_o},    32'h0);
    check("rst_re",    {31'd0, reg_re_o},    32'h0);
    check("rst_busy",  {31'd0, busy_o},      32'h0);
    check("rst_siod_released", {31'd0, (siod !== 1'b0)}, 32'h1);
    rst_i = 1'b1;
    wait_clk(4);

    // 1: 3-phase write 0x42 / 0x12 / 0x80
    we0 = we_cnt;
    start_cond();
    write_byte(8'h42, a0);
    write_byte(8'h12, a1);
    write_byte(8'h80, a2);
    check("t1_busy_mid", {31'd0, busy_o}, 32'h1);
    stop_cond();
    check("t1_ack_id",   {31'd0, a0}, 32'h1);
    check("t1_ack_reg",  {31'd0, a1}, 32'h1);
    check("t1_ack_data", {31'd0, a2}, 32'h1);
    check("t1_we_count", we_cnt - we0, 32'd1);
    check("t1_we_addr",  {24'd0, we_addr_log[we0 % 32]}, 32'h12);
    check("t1_we_data",  {24'd0, we_data_log[we0 % 32]}, 32'h80);
    check("t1_busy_after_stop", {31'd0, busy_o}, 32'h0);

    // 2: 2-phase write sets address 0x0A, then read returns 0x76 with NA
    reg_rdata_i = 8'h76;
    start_cond();
    write_byte(8'h42, a0);
    write_byte(8'h0A, a1);
    stop_cond();
    re0 = re_cnt;
    we0 = we_cnt;
    start_cond();
    write_byte(8'h43, a2);
    read_byte(1'b1, rb);
    check("t2_busy_after_na", {31'd0, busy_o}, 32'h1);
    stop_cond();
    check("t2_ack_id_w",  {31'd0, a0}, 32'h1);
    check("t2_ack_reg",   {31'd0, a1}, 32'h1);
    check("t2_ack_id_r",  {31'd0, a2}, 32'h1);
    check("t2_rd_bits",   {24'd0, rb}, 32'h76);
    check("t2_re_count",  re_cnt - re0, 32'd1);
    check("t2_re_addr",   {24'd0, re_addr_log[re0 % 32]}, 32'h0A);
    check("t2_no_we",     we_cnt - we0, 32'd0);
    check("t2_busy_after_stop", {31'd0, busy_o}, 32'h0);

    // 3: foreign ID 0x60 is ignored entirely
    we0 = we_cnt; re0 = re_cnt; drv0 = drv_cnt; busy0 = busy_cnt;
    start_cond();
    write_byte(8'h60, a0);
    write_byte(8'h12, a1);
    write_byte(8'h55, a2);
    stop_cond();
    check("t3_no_ack_id", {31'd0, a0}, 32'h0);
    check("t3_no_ack_b1", {31'd0, a1}, 32'h0);
    check("t3_no_ack_b2", {31'd0, a2}, 32'h0);
    check("t3_never_driven", drv_cnt - drv0, 32'd0);
    check("t3_no_we", we_cnt - we0, 32'd0);
    check("t3_no_re", re_cnt - re0, 32'd0);
    check("t3_busy_never", busy_cnt - busy0, 32'd0);

    // 4: burst write wraps address 0xFF -> 0x00
    we0 = we_cnt;
    start_cond();
    write_byte(8'h42, a0);
    write_byte(8'hFF, a1);
    write_byte(8'h11, a2);
    write_byte(8'h22, a3);
    stop_cond();
    check("t4_ack_d2",     {31'd0, a3}, 32'h1);
    check("t4_we_count",   we_cnt - we0, 32'd2);
    check("t4_we0_addr",   {24'd0, we_addr_log[we0 % 32]}, 32'hFF);
    check("t4_we0_data",   {24'd0, we_data_log[we0 % 32]}, 32'h11);
    check("t4_we1_addr",   {24'd0, we_addr_log[(we0 + 1) % 32]}, 32'h00);
    check("t4_we1_data",   {24'd0, we_data_log[(we0 + 1) % 32]}, 32'h22);

    // 5: STOP after 5 data bits aborts the write
    start_cond();
    write_byte(8'h42, a0);
    write_byte(8'h20, a1);
    we0 = we_cnt;
    write_bits(8'hA5, 5);
    stop_cond();
    check("t5_no_we",      we_cnt - we0, 32'd0);
    check("t5_addr_kept",  {24'd0, reg_addr_o}, 32'h20);
    check("t5_busy",       {31'd0, busy_o}, 32'h0);
    check("t5_state_idle", {29'd0, dut.state_q}, 32'd0);

    // 6: async reset while the target drives a 0 read bit
    reg_rdata_i = 8'h76;
    start_cond();
    write_byte(8'h43, a0);
    check("t6_driving_zero", {31'd0, (siod === 1'b0)}, 32'h1);
    rst_i = 1'b0;
    wait_clk(1);
    check("t6_siod_released", {31'd0, (siod !== 1'b0)}, 32'h1);
    check("t6_addr",  {24'd0, reg_addr_o},  32'h00);
    check("t6_wdata", {24'd0, reg_wdata_o}, 32'h00);
    check("t6_we_re", {30'd0, reg_we_o, reg_re_o}, 32'h0);
    check("t6_busy",  {31'd0, busy_o}, 32'h0);
    rst_i = 1'b1;
    sioc  = 1'b1;
    wait_clk(2 * Q);
    we0 = we_cnt;
    start_cond();
    write_byte(8'h42, a0);
    write_byte(8'h33, a1);
    write_byte(8'h5A, a2);
    stop_cond();
    check("t6_post_acks",  {29'd0, a0, a1, a2}, 32'h7);
    check("t6_post_we",    we_cnt - we0, 32'd1);
    check("t6_post_addr",  {24'd0, we_addr_log[we0 % 32]}, 32'h33);
    check("t6_post_data",  {24'd0, we_data_log[we0 % 32]}, 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
